// File: rtl/clint_timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clint_timer_pkg                                              |
// | Description : Shared definitions for the core-local interruptor: register  |
// |               offsets inside the CLINT window, bus FSM state encodings and |
// |               the mtimecmp reset value.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package clint_timer_pkg;

  // Byte offsets of the mapped registers (all word aligned).
  localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;

  // Bus responder FSM encoding.
  localparam int unsigned CLINT_STATE_W = 1;
  localparam logic [CLINT_STATE_W-1:0] CLINT_IDLE = 1'b0;
  localparam logic [CLINT_STATE_W-1:0] CLINT_RESP = 1'b1;

  // mtimecmp resets to all-ones so no timer interrupt is raised out of reset.
  localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage : clint_timer_pkg
`default_nettype wire

// File: rtl/clint_timer_mtime.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clint_timer_mtime                                            |
// | Description : Prescaler plus the 64-bit mtime counter with independent     |
// |               32-bit half-word write ports. Optional macro                 |
// |               CLINT_TIME_LATCH_EN adds a shadow of mtime[63:32] captured   |
// |               on every mtime-lo read, giving tear-free lo-then-hi reads.   |
// | Ports       : clk, rst_n        clock / async active-low reset             |
// |               wr_lo_i, wr_hi_i  write strobe for mtime[31:0] / [63:32]     |
// |               rd_lo_i           accepted read of mtime lo (shadow capture) |
// |               wdata_i           32-bit write data                          |
// |               tick_o            prescaler tick (mtime increments)          |
// |               mtime_lo_o        live mtime[31:0]                           |
// |               mtime_hi_rd_o     value returned by an mtime-hi read         |
// |               mtime_next_o      mtime value after the current edge         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module clint_timer_mtime #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic        rd_lo_i,
  input  logic [31:0] wdata_i,
  output logic        tick_o,
  output logic [31:0] mtime_lo_o,
  output logic [31:0] mtime_hi_rd_o,
  output logic [63:0] mtime_next_o
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      mtime_q, mtime_d;

  assign tick_o = (cnt_q == CNT_MAX);
  assign cnt_d  = tick_o ? '0 : cnt_q + CNT_W'(1);

  // A half-word write replaces only its own half and suppresses the tick's
  // increment for that edge; the untouched half keeps its pre-edge value.
  always_comb begin
    mtime_d = tick_o ? (mtime_q + 64'd1) : mtime_q;
    if (wr_lo_i) begin
      mtime_d = {mtime_q[63:32], wdata_i};
    end else if (wr_hi_i) begin
      mtime_d = {wdata_i, mtime_q[31:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mtime_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      mtime_q <= mtime_d;
    end
  end

  assign mtime_lo_o   = mtime_q[31:0];
  assign mtime_next_o = mtime_d;

`ifdef CLINT_TIME_LATCH_EN
  logic [31:0] shadow_q, shadow_d;

  // The shadow captures the pre-edge high half, matching the pre-edge value
  // returned by the lo read that triggered the capture.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_hi_i) begin
      shadow_d = wdata_i;
    end else if (rd_lo_i) begin
      shadow_d = mtime_q[63:32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign mtime_hi_rd_o = shadow_q;
`else
  logic unused_rd_lo;
  assign unused_rd_lo  = rd_lo_i;
  assign mtime_hi_rd_o = mtime_q[63:32];
`endif

endmodule : clint_timer_mtime
`default_nettype wire

// File: rtl/clint_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clint_timer                                                  |
// | Description : Core-local interruptor. Memory-mapped responder holding      |
// |               msip, the 64-bit mtimecmp and (via clint_timer_mtime) the    |
// |               64-bit mtime; drives registered msip/mtip into the core.     |
// |               Optional macro CLINT_TIME_LATCH_EN enables the tear-free     |
// |               mtime-hi shadow read.                                        |
// | Ports       : clk, rst_n                 clock / async active-low reset    |
// |               req_valid/ready/we/addr/wdata   request channel              |
// |               rsp_valid/ready/rdata/err       response channel             |
// |               msip, mtip                  interrupt levels to the core     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              msip,
  output logic              mtip
);

  localparam logic [ADDR_W-1:0] MSIP_OFF   = ADDR_W'(CLINT_MSIP_OFF);
  localparam logic [ADDR_W-1:0] CMP_LO_OFF = ADDR_W'(CLINT_MTIMECMP_LO_OFF);
  localparam logic [ADDR_W-1:0] CMP_HI_OFF = ADDR_W'(CLINT_MTIMECMP_HI_OFF);
  localparam logic [ADDR_W-1:0] TIME_LO_OFF = ADDR_W'(CLINT_MTIME_LO_OFF);
  localparam logic [ADDR_W-1:0] TIME_HI_OFF = ADDR_W'(CLINT_MTIME_HI_OFF);

  logic [CLINT_STATE_W-1:0] state_q, state_d;

  logic        msip_q, msip_d;
  logic        mtip_q, mtip_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        accept, wr_en;
  logic        aligned;
  logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi, sel_err;
  logic [31:0] rd_val;

  logic        mtime_tick;
  logic [31:0] mtime_lo, mtime_hi_rd;
  logic [63:0] mtime_next;

  // ---------------------------------------------------------------- decode
  assign accept  = (state_q == CLINT_IDLE) && req_valid;
  assign wr_en   = accept && req_we;
  assign aligned = (req_addr[1:0] == 2'b00);

  assign sel_msip    = aligned && (req_addr == MSIP_OFF);
  assign sel_cmp_lo  = aligned && (req_addr == CMP_LO_OFF);
  assign sel_cmp_hi  = aligned && (req_addr == CMP_HI_OFF);
  assign sel_time_lo = aligned && (req_addr == TIME_LO_OFF);
  assign sel_time_hi = aligned && (req_addr == TIME_HI_OFF);
  assign sel_err     = !(sel_msip || sel_cmp_lo || sel_cmp_hi || sel_time_lo || sel_time_hi);

  // ---------------------------------------------------------------- mtime
  clint_timer_mtime #(
    .PRESCALE (PRESCALE)
  ) u_mtime (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_lo_i       (wr_en && sel_time_lo),
    .wr_hi_i       (wr_en && sel_time_hi),
    .rd_lo_i       (accept && !req_we && sel_time_lo),
    .wdata_i       (req_wdata),
    .tick_o        (mtime_tick),
    .mtime_lo_o    (mtime_lo),
    .mtime_hi_rd_o (mtime_hi_rd),
    .mtime_next_o  (mtime_next)
  );

  logic unused_tick;
  assign unused_tick = mtime_tick;

  // ---------------------------------------------------------------- registers
  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    if (wr_en) begin
      if (sel_msip)   msip_d            = req_wdata[0];
      if (sel_cmp_lo) mtimecmp_d[31:0]  = req_wdata;
      if (sel_cmp_hi) mtimecmp_d[63:32] = req_wdata;
    end
  end

  // Compare the post-edge values so mtip tracks exactly one cycle behind
  // either a counter crossing or a software update of mtimecmp.
  assign mtip_d = (mtime_next >= mtimecmp_d);

  // Read data reflects register contents before the accepting edge.
  always_comb begin
    rd_val = 32'h0;
    if (sel_msip)    rd_val = {31'h0, msip_q};
    if (sel_cmp_lo)  rd_val = mtimecmp_q[31:0];
    if (sel_cmp_hi)  rd_val = mtimecmp_q[63:32];
    if (sel_time_lo) rd_val = mtime_lo;
    if (sel_time_hi) rd_val = mtime_hi_rd;
  end

  always_comb begin
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_err_d   = sel_err;
      rsp_rdata_d = (req_we || sel_err) ? 32'h0 : rd_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msip_q      <= 1'b0;
      mtip_q      <= 1'b0;
      mtimecmp_q  <= CLINT_MTIMECMP_RST;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      msip_q      <= msip_d;
      mtip_q      <= mtip_d;
      mtimecmp_q  <= mtimecmp_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // ---------------------------------------------------------------- bus FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLINT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLINT_IDLE: if (req_valid) state_d = CLINT_RESP;
      CLINT_RESP: if (rsp_ready) state_d = CLINT_IDLE;
      default:    state_d = CLINT_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      CLINT_IDLE: req_ready = 1'b1;
      CLINT_RESP: rsp_valid = 1'b1;
      default:    req_ready = 1'b0;
    endcase
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign msip      = msip_q;
  assign mtip      = mtip_q;

endmodule : clint_timer
`default_nettype wire

// File: tb/tb_clint_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_clint_timer                                               |
// | Description : Self-checking bench for clint_timer. A reference model keeps |
// |               mtime as (base value + elapsed cycles since base), plus      |
// |               mtimecmp, msip and the hi shadow (CLINT_TIME_LATCH_EN).      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_clint_timer;

  localparam int unsigned PRESCALE = 1;
  localparam int unsigned ADDR_W   = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              msip;
  logic              mtip;

  always #5 clk = ~clk;

  clint_timer #(
    .PRESCALE (PRESCALE),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .msip      (msip),
    .mtip      (mtip)
  );

  int checks = 0;
  int errors = 0;

  // Clock edges seen out of reset; with PRESCALE = 1 every one is a tick.
  logic [63:0] cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 64'd0;
    else        cyc <= cyc + 64'd1;
  end

  // ------------------------------------------------------------ reference model
  logic [63:0] m_base, m_base_cyc, m_cmp;
  logic        m_msip;
  logic [31:0] m_shadow;

  function automatic logic [63:0] m_time(input logic [63:0] c);
    return m_base + (c - m_base_cyc);
  endfunction

  task automatic model_reset();
    m_base     = 64'd0;
    m_base_cyc = 64'd0;
    m_cmp      = 64'hFFFF_FFFF_FFFF_FFFF;
    m_msip     = 1'b0;
    m_shadow   = 32'd0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_irq();
    chk("mtip", 64'(mtip), 64'(m_time(cyc) >= m_cmp));
    chk("msip", 64'(msip), 64'(m_msip));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check_irq();
    end
  endtask

  // One complete transaction; entered and left at a negedge with the DUT idle.
  task automatic bus(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                     input int hold);
    logic [63:0] c0, t;
    logic [31:0] exp_rd;
    logic        exp_err;
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = (hold == 0);
    c0 = cyc;
    t  = m_time(c0);
    exp_err = 1'b0;
    exp_rd  = 32'd0;
    case (addr)
      16'h0000: exp_rd = {31'd0, m_msip};
      16'h4000: exp_rd = m_cmp[31:0];
      16'h4004: exp_rd = m_cmp[63:32];
      16'hBFF8: exp_rd = t[31:0];
`ifdef CLINT_TIME_LATCH_EN
      16'hBFFC: exp_rd = m_shadow;
`else
      16'hBFFC: exp_rd = t[63:32];
`endif
      default:  exp_err = 1'b1;
    endcase
    if (we || exp_err) exp_rd = 32'd0;
    @(negedge clk);
    req_valid = 1'b0;
    // Effect of the accepting edge.
    if (!exp_err) begin
      if (we) begin
        case (addr)
          16'h0000: m_msip = wdata[0];
          16'h4000: m_cmp[31:0] = wdata;
          16'h4004: m_cmp[63:32] = wdata;
          16'hBFF8: begin m_base = {t[63:32], wdata}; m_base_cyc = c0 + 64'd1; end
          16'hBFFC: begin m_base = {wdata, t[31:0]}; m_base_cyc = c0 + 64'd1; m_shadow = wdata; end
          default: ;
        endcase
      end else if (addr == 16'hBFF8) begin
        m_shadow = t[63:32];
      end
    end
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("req_ready_busy", 64'(req_ready), 64'd0);
    chk($sformatf("rdata@%h", addr), 64'(rsp_rdata), 64'(exp_rd));
    chk($sformatf("err@%h", addr), 64'(rsp_err), 64'(exp_err));
    check_irq();
    if (hold > 0) begin
      // A competing msip write must not be taken while the response is pending.
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 16'h0000;
      req_wdata = {31'd0, ~m_msip};
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", 64'(rsp_valid), 64'd1);
        chk("hold_rdata", 64'(rsp_rdata), 64'(exp_rd));
        chk("hold_ready", 64'(req_ready), 64'd0);
        check_irq();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk("rsp_done", 64'(rsp_valid), 64'd0);
    check_irq();
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    logic [15:0] addrs [7];
    logic [15:0] a;
    logic [31:0] d;
    addrs[0] = 16'h0000; addrs[1] = 16'h4000; addrs[2] = 16'h4004; addrs[3] = 16'hBFF8;
    addrs[4] = 16'hBFFC; addrs[5] = 16'h1000; addrs[6] = 16'h4002;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_msip", 64'(msip), 64'd0);
    chk("rst_mtip", 64'(mtip), 64'd0);
    rst_n = 1'b1;

    // Free-running count: 10 ticks then read lo (expects 0x0A).
    idle(10);
    chk("mtime_after_10", m_time(cyc), 64'd10);
    bus(1'b0, 16'hBFF8, 32'd0, 0);

    // Timer compare crossing and withdrawal.
    bus(1'b1, 16'h4004, 32'h0, 0);
    bus(1'b1, 16'h4000, 32'h20, 0);
    idle(30);
    chk("mtip_raised", 64'(mtip), 64'd1);
    bus(1'b1, 16'h4000, 32'hFFFF_FFFF, 0);
    chk("mtip_fell", 64'(mtip), 64'd0);

    // Software interrupt.
    bus(1'b1, 16'h0000, 32'h1, 0);
    bus(1'b0, 16'h0000, 32'h0, 0);
    bus(1'b1, 16'h0000, 32'hFFFF_FFFE, 0);
    bus(1'b0, 16'h0000, 32'h0, 0);

    // Carry across halves, writes on tick edges drop the increment.
    bus(1'b1, 16'hBFF8, 32'hFFFF_FFFE, 0);
    bus(1'b1, 16'hBFFC, 32'h0, 0);
    bus(1'b0, 16'hBFFC, 32'h0, 0);
    bus(1'b0, 16'hBFF8, 32'h0, 0);

    // Lo read at 0xFFFF_FFFF then hi after the carry (shadow vs live).
    bus(1'b1, 16'hBFFC, 32'h0, 0);
    bus(1'b1, 16'hBFF8, 32'hFFFF_FFFE, 0);
    bus(1'b0, 16'hBFF8, 32'h0, 0);
    bus(1'b0, 16'hBFFC, 32'h0, 0);

    // 64-bit wrap to zero.
    bus(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 0);
    bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 0);
    bus(1'b0, 16'hBFF8, 32'h0, 0);
    bus(1'b0, 16'hBFFC, 32'h0, 0);

    // Unmapped and misaligned accesses leave state untouched.
    bus(1'b0, 16'h1000, 32'h0, 0);
    bus(1'b0, 16'h4002, 32'h0, 0);
    bus(1'b1, 16'h1000, 32'h1, 0);
    bus(1'b1, 16'h4002, 32'h1234_5678, 0);
    bus(1'b1, 16'hBFF9, 32'h0, 0);
    bus(1'b0, 16'h4000, 32'h0, 0);
    bus(1'b0, 16'h0000, 32'h0, 0);

    // Back-pressure on the response.
    bus(1'b0, 16'h4000, 32'h0, 5);

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      a = addrs[$urandom_range(0, 6)];
      d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 300));
      bus(1'($urandom_range(0, 1)), a, d, int'($urandom_range(0, 2)));
      idle(int'($urandom_range(0, 2)));
    end

    // Reset while a response is pending.
    bus(1'b1, 16'h0000, 32'h1, 0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h4000; rsp_ready = 1'b0;
    @(negedge clk);
    chk("mid_rsp_valid", 64'(rsp_valid), 64'd1);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_rdata", 64'(rsp_rdata), 64'd0);
    chk("mid_rst_msip", 64'(msip), 64'd0);
    chk("mid_rst_mtip", 64'(mtip), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    bus(1'b0, 16'h4000, 32'h0, 0);
    bus(1'b0, 16'hBFF8, 32'h0, 0);
    bus(1'b0, 16'h0000, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule : tb_clint_timer
`default_nettype wire

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Core-local interruptor; the source end of the msip/mtip interrupt lines that the CSR handler consumes.
- Memory-mapped responder on the data-side peripheral bus.
- Holds the 64-bit mtime counter, the 64-bit mtimecmp register and the msip bit.
- Drives registered msip/mtip level interrupts into the core.

Parameters:
- PRESCALE, 1: clk cycles per mtime increment; must be >= 1.
- ADDR_W, 16: width of the offset address within the CLINT window.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  bus request valid
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte offset; word aligned
- req_wdata  in  32  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  requester accepts response
- rsp_rdata  out  32  read data (0 on writes and errors)
- rsp_err  out  1  unmapped or misaligned access
- msip  out  1  machine software interrupt pending
- mtip  out  1  machine timer interrupt pending

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Register map:
  - 0x0000 msip: bit0 is R/W, bits 31:1 read 0.
  - 0x4000 mtimecmp[31:0]
  - 0x4004 mtimecmp[63:32]
  - 0xBFF8 mtime[31:0]
  - 0xBFFC mtime[63:32]
  - Any other offset, or addr[1:0] != 0: rsp_err = 1, no state change, rdata = 0.
- Reset values:
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0, mtip = 0.
  - Prescaler count = 0, FSM = IDLE.
  - req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- FSM with two states, IDLE and RESP:
  - IDLE: req_ready = 1. On req_valid, perform the access, register rdata/err, go to RESP.
  - RESP: rsp_valid = 1, req_ready = 0. rsp_* held stable until rsp_ready, then back to IDLE.
  - Latency is exactly 1 cycle from request acceptance to rsp_valid. Maximum throughput is one request per 2 cycles.
  - The write takes effect at the accepting clock edge; a read returns the value before that edge.
- Prescaler:
  - Counter 0..PRESCALE-1. A tick fires when count == PRESCALE-1, then the count wraps to 0.
  - PRESCALE = 1 means a tick every cycle.
- mtime:
  - Increments by 1 on each tick; 64-bit wrap from all-ones to 0.
  - The carry from the low to the high half is internal to the single 64-bit add.
- Software write to mtime lo or hi on the same edge as a tick: the write wins, the increment is lost for that tick, and the other half is unchanged.
- 32-bit write to one half never carries into, or otherwise modifies, the other half.
- mtip:
  - Registered: mtip <= (mtime_next >= mtimecmp_next), unsigned 64-bit compare.
  - Asserts the cycle after the crossing; deasserts the cycle after mtimecmp is raised above mtime.
- msip follows the stored bit directly as a registered output.
- Reset mid-transaction: the FSM returns to IDLE immediately, the pending response is dropped, and all registers go to their reset values.

Optional Feature:
- Macro: CLINT_TIME_LATCH_EN.
- Defined:
  - Reading mtime lo also snapshots mtime[63:32] into a shadow register.
  - Reading mtime hi returns the shadow, not the live value, giving a tear-free 64-bit read as lo then hi.
  - Shadow resets to 0.
  - A write to mtime hi updates both live and shadow.
- Undefined: mtime hi reads return the live value; no shadow register exists.

Decomposition:
- Shared package/defines file (clint_defs): register offsets CLINT_MSIP_OFF, CLINT_MTIMECMP_LO_OFF/HI_OFF, CLINT_MTIME_LO_OFF/HI_OFF; FSM state encodings CLINT_IDLE, CLINT_RESP; mtimecmp reset constant.
- One sub-module is natural: clint_mtime, containing the prescaler, the 64-bit counter with half-word write ports, the optional shadow, and the tick output.
- The bus FSM, msip and mtimecmp stay in the top level.

Test Plan:
- Reset, then idle 10 cycles with PRESCALE=1 -> mtime lo reads 0x0000000A±1 (exact per 1-cycle read latency); mtip = 0; msip = 0; all rsp outputs 0 during reset.
- Write mtimecmp hi = 0 then lo = 0x20 -> mtip rises exactly one cycle after mtime reaches 0x20; write mtimecmp lo = 0xFFFF_FFFF -> mtip falls the following cycle.
- Write 1 to 0x0000 -> msip = 1 next cycle, read returns 0x1; write 0 -> msip = 0.
- Write mtime lo = 0xFFFF_FFFE, hi = 0x0 -> after 2 ticks, hi reads 0x1 and lo reads 0x0 (carry across halves); write on a tick edge loses that increment.
- Read offset 0x1000 and offset 0x4002 -> rsp_err = 1, rdata = 0, no register changes.
- Hold rsp_ready = 0 for 5 cycles -> rsp_valid and rdata stay stable, req_ready = 0, the next request is not accepted until the handshake. With CLINT_TIME_LATCH_EN: read lo at 0xFFFF_FFFF, then hi after the carry -> hi returns the pre-carry value 0.
